// File: rtl/control_unit.sv
// control_unit
//   Multicycle Moore control FSM for the 4-bit-opcode accumulator datapath.
//   It sequences fetch, decode, memory access, ALU execute and writeback, and
//   drives every datapath enable and select line.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset (0 = in reset)
//   opcode[3:0]    instruction register bits [15:12]
//   toCU           branch condition from the datapath flags (used in DECODE)
//   pcEn           PC load
//   selAddress     memory address select (0 = PC, 1 = instruction address)
//   mr, mw         memory read / write strobes
//   wordRegEn      latch memory word into the instruction register
//   DIEn           latch memory word into the data-in register
//   LSEn, RSEn     accumulator shift left / right
//   selData[1:0]   accumulator source (00 = result reg, 01 = data-in)
//   selAddressAC   PC source (00 = PC+1, 01 = instruction address)
//   selALUsrc      ALU B operand (0 = data-in, 1 = zero)
//   operation[2:0] ALU op (000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A)
//   enb            accumulator write
//   dataRegEn      reserved, tied 0
//   resultRegEn    latch ALU output
//   CEn, ZEn, NEn  flag register loads
//   halted         high while in HALT
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       toCU,
  output logic       pcEn,
  output logic       selAddress,
  output logic       mr,
  output logic       mw,
  output logic       wordRegEn,
  output logic       DIEn,
  output logic       LSEn,
  output logic       RSEn,
  output logic [1:0] selData,
  output logic [1:0] selAddressAC,
  output logic       selALUsrc,
  output logic [2:0] operation,
  output logic       enb,
  output logic       dataRegEn,
  output logic       resultRegEn,
  output logic       CEn,
  output logic       ZEn,
  output logic       NEn,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMRD, S_EXEC,
    S_WB, S_STORE, S_JUMP, S_SHIFT, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       sel_address;
    logic       mr;
    logic       mw;
    logic       word_reg_en;
    logic       di_en;
    logic       ls_en;
    logic       rs_en;
    logic [1:0] sel_data;
    logic [1:0] sel_address_ac;
    logic       sel_alu_src;
    logic [2:0] operation;
    logic       enb;
    logic       result_reg_en;
    logic       c_en;
    logic       z_en;
    logic       n_en;
    logic       halted;
  } ctrl_t;

  state_t state, state_nxt;
  ctrl_t  ctrl_q, ctrl_nxt;
  logic [3:0] op_minus3;

  assign op_minus3 = opcode - 4'd3;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          4'h1, 4'h3, 4'h4, 4'h5, 4'h6: state_nxt = S_MEMRD;
          4'h2:                         state_nxt = S_STORE;
          4'h7:                         state_nxt = S_EXEC;
          4'h8, 4'h9:                   state_nxt = S_SHIFT;
          4'hA:                         state_nxt = S_JUMP;
          4'hB:                         state_nxt = toCU ? S_JUMP : S_FETCH;
          4'hC:                         state_nxt = S_HALT;
          default:                      state_nxt = S_FETCH;
        endcase
      end
      S_MEMRD:  state_nxt = (opcode == 4'h1) ? S_WB : S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB, S_STORE, S_JUMP, S_SHIFT: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  // Opcode is stable across that edge everywhere it matters (the instruction
  // register only loads at the end of FETCH, and DECODE outputs are all 0).
  always_comb begin
    ctrl_nxt = '0;
    unique case (state_nxt)
      S_FETCH: begin
        ctrl_nxt.mr          = 1'b1;
        ctrl_nxt.word_reg_en = 1'b1;
        ctrl_nxt.pc_en       = 1'b1;
      end
      S_MEMRD: begin
        ctrl_nxt.sel_address = 1'b1;
        ctrl_nxt.mr          = 1'b1;
        ctrl_nxt.di_en       = 1'b1;
      end
      S_EXEC: begin
        ctrl_nxt.result_reg_en = 1'b1;
        ctrl_nxt.z_en          = 1'b1;
        ctrl_nxt.n_en          = 1'b1;
        if (opcode == 4'h7) begin
          ctrl_nxt.operation   = 3'b100;
          ctrl_nxt.sel_alu_src = 1'b1;
        end else begin
          ctrl_nxt.operation = op_minus3[2:0];
          ctrl_nxt.c_en      = (opcode == 4'h3) || (opcode == 4'h4);
        end
      end
      S_WB: begin
        ctrl_nxt.enb      = 1'b1;
        ctrl_nxt.sel_data = (opcode == 4'h1) ? 2'b01 : 2'b00;
      end
      S_STORE: begin
        ctrl_nxt.sel_address = 1'b1;
        ctrl_nxt.mw          = 1'b1;
      end
      S_JUMP: begin
        ctrl_nxt.pc_en          = 1'b1;
        ctrl_nxt.sel_address_ac = 2'b01;
      end
      S_SHIFT: begin
        ctrl_nxt.ls_en = (opcode == 4'h8);
        ctrl_nxt.rs_en = (opcode == 4'h9);
      end
      S_HALT:  ctrl_nxt.halted = 1'b1;
      default: ctrl_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= ctrl_nxt;
    end
  end

  assign pcEn         = ctrl_q.pc_en;
  assign selAddress   = ctrl_q.sel_address;
  assign mr           = ctrl_q.mr;
  assign mw           = ctrl_q.mw;
  assign wordRegEn    = ctrl_q.word_reg_en;
  assign DIEn         = ctrl_q.di_en;
  assign LSEn         = ctrl_q.ls_en;
  assign RSEn         = ctrl_q.rs_en;
  assign selData      = ctrl_q.sel_data;
  assign selAddressAC = ctrl_q.sel_address_ac;
  assign selALUsrc    = ctrl_q.sel_alu_src;
  assign operation    = ctrl_q.operation;
  assign enb          = ctrl_q.enb;
  assign dataRegEn    = 1'b0;
  assign resultRegEn  = ctrl_q.result_reg_en;
  assign CEn          = ctrl_q.c_en;
  assign ZEn          = ctrl_q.z_en;
  assign NEn          = ctrl_q.n_en;
  assign halted       = ctrl_q.halted;

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM that sits opposite the accumulator datapath. It receives the opcode and the branch-condition bit (`toCU`) from the datapath, and drives every datapath enable and select line. It sequences fetch, decode, memory access, ALU execute and writeback for a 4-bit-opcode accumulator ISA. It is a Moore machine with one clock; all datapath register updates happen on the rising edge that ends the state in which the enable is asserted.

## Interface
- No parameters. Widths are fixed by the datapath.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset; asserted when 0.
- `opcode` in 4: instruction register bits [15:12]; valid from DECODE onward.
- `toCU` in 1: branch condition from the datapath flags; sampled only in DECODE.
- `pcEn` out 1: PC load.
- `selAddress` out 1: memory address select; 0 = PC, 1 = instruction address field.
- `mr`, `mw` out 1: memory read and write strobes.
- `wordRegEn` out 1: latch the memory word into the instruction register.
- `DIEn` out 1: latch the memory word into the data-in register.
- `LSEn`, `RSEn` out 1: shift the accumulator left or right by 1.
- `selData` out 2: accumulator source; 00 = result register, 01 = data-in, 10/11 unused.
- `selAddressAC` out 2: PC source; 00 = PC+1, 01 = instruction address, 10/11 unused.
- `selALUsrc` out 1: ALU B operand; 0 = data-in, 1 = zero.
- `operation` out 3: ALU op; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A.
- `enb` out 1: accumulator write.
- `dataRegEn` out 1: reserved; always 0.
- `resultRegEn` out 1: latch the ALU output.
- `CEn`, `ZEn`, `NEn` out 1: flag register loads.
- `halted` out 1: high while in HALT.

## Operation
- Opcodes:
  - 0 NOP
  - 1 LDA: AC ← M[a]
  - 2 STA: M[a] ← AC
  - 3 ADD, 4 SUB, 5 AND, 6 OR: AC ← AC op M[a]
  - 7 NOT: AC ← ~AC
  - 8 SHL, 9 SHR
  - A JMP
  - B BRC: jump if `toCU`
  - C HLT
  - D–F are illegal and execute as NOP.
- States: IDLE, FETCH, DECODE, MEMRD, EXEC, WB, STORE, JUMP, SHIFT, HALT.
- Any output not listed for a state is 0. `operation` defaults to 000.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: `selAddress`=0, `mr`, `wordRegEn`, `pcEn`, `selAddressAC`=00. Next state is DECODE.
- DECODE: all outputs 0. Next state by opcode:
  - 1, 3–6 → MEMRD
  - 2 → STORE
  - 7 → EXEC
  - 8, 9 → SHIFT
  - A → JUMP
  - B → JUMP if `toCU`=1, else FETCH
  - C → HALT
  - 0, D–F → FETCH
- MEMRD: `selAddress`=1, `mr`, `DIEn`. Next state is WB for LDA, EXEC for opcodes 3–6.
- EXEC: `resultRegEn`; `operation` = opcode−3 for opcodes 3–6, 100 for NOT; `selALUsrc`=1 for NOT only. Flag enables:
  - ADD/SUB: `CEn`, `ZEn`, `NEn`.
  - AND/OR/NOT: `ZEn`, `NEn` only.
  - Next state is WB.
- WB: `enb`; `selData`=01 for LDA, 00 otherwise. Next state is FETCH.
- STORE: `selAddress`=1, `mw`. Next state is FETCH.
- JUMP: `pcEn`, `selAddressAC`=01. Next state is FETCH.
- SHIFT: `LSEn` for SHL, `RSEn` for SHR (never both). Next state is FETCH.
- HALT: `halted`=1, all other outputs 0. Stays in HALT until reset.
- `opcode` is re-sampled every cycle. Opcode-dependent outputs in MEMRD, EXEC, WB and SHIFT use the current `opcode`, which the datapath holds stable because `wordRegEn` is 0 outside FETCH.

## Timing
- Reset assertion forces IDLE asynchronously. All outputs are 0 immediately, with no clock required.
- Deassertion: first rising edge enters FETCH. Reset mid-instruction abandons it; `mw` drops immediately.
- Cycles per instruction, FETCH inclusive:
  - NOP/illegal: 2
  - BRC not taken: 2
  - BRC taken: 3
  - STA, JMP, SHL, SHR: 3
  - LDA, NOT: 4
  - ADD/SUB/AND/OR: 5
- `mr` and `mw` are never high in the same cycle.
- `pcEn` is high only in FETCH and JUMP.
- `enb` is high only in WB.
- Outputs are purely state/opcode decoded, with no input-to-output path except `opcode`.
- `toCU` is used only for the DECODE→next-state decision.

## Test plan
- Reset: drive `reset`=0 mid-cycle → all outputs 0 with no clock edge. Release → one IDLE cycle, then FETCH with `mr`=`wordRegEn`=`pcEn`=1 and `selAddress`=0.
- ADD (opcode 3): state trace FETCH, DECODE, MEMRD, EXEC, WB, FETCH. In EXEC, `operation`=000 and `CEn`=`ZEn`=`NEn`=1. In WB, `enb`=1 and `selData`=00.
- LDA then STA: LDA WB has `selData`=01. STA is 3 cycles with `mw`=1 only in STORE and `selAddress`=1. `mr`·`mw` is never 1 over the whole run.
- BRC (opcode B): with `toCU`=0 → FETCH follows DECODE (2 cycles), `pcEn` not asserted outside FETCH. With `toCU`=1 → JUMP with `pcEn`=1 and `selAddressAC`=01.
- SHL, SHR, NOT and illegal opcode E:
  - SHL asserts `LSEn` only; SHR asserts `RSEn` only.
  - NOT has `operation`=100, `selALUsrc`=1 and `CEn`=0.
  - E returns to FETCH after 2 cycles.
- HLT: `halted`=1 and stays 1 for 20 cycles with all other outputs 0. Asserting `reset` clears `halted` asynchronously.
